// File: rtl/em_stage_reg_pkg.sv
// Shared pipeline package: forward-data op codes, the Tnew "no result" code
// and the default reset PC. The CU blocks and the E/M and M/W stage
// registers all use these.
package em_stage_reg_pkg;

   // Source of the value a stage forwards back to D/E
   localparam logic [1:0] FW_OP_ALU  = 2'b00;
   localparam logic [1:0] FW_OP_MEM  = 2'b01;
   localparam logic [1:0] FW_OP_PC8  = 2'b10;
   localparam logic [1:0] FW_OP_NONE = 2'b11;

   // Tnew code for an instruction that produces no register result
   localparam logic [1:0] TNEW_NONE  = 2'b11;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Tnew one stage later. Saturates at 0: a result that is already
   // available stays available.
   function automatic logic [1:0] tnew_next(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

endpackage

// File: rtl/em_stage_reg_fw_data_sel.sv
// fw_data_sel: picks the value a pipeline stage forwards back to D/E and
// says whether it is usable this cycle. Shared by the M and W stages.
//   i_op    forward-data op code of the stage's instruction
//   i_addr  destination register (0 = no write)
//   i_tnew  cycles until the result exists in this stage
//   i_alu   ALU result held by the stage
//   i_pc    PC held by the stage (link value is PC+8)
//   o_data  forward value (0 when the source is not available here)
//   o_valid 1 = o_data may be selected by the forwarding muxes
module fw_data_sel
   import em_stage_reg_pkg::*;
(
   input  logic [1:0]  i_op,
   input  logic [4:0]  i_addr,
   input  logic [1:0]  i_tnew,
   input  logic [31:0] i_alu,
   input  logic [31:0] i_pc,
   output logic [31:0] o_data,
   output logic        o_valid
);

   always_comb begin
      o_data = 32'd0;
      case (i_op)
         FW_OP_ALU: o_data = i_alu;
         FW_OP_PC8: o_data = i_pc + 32'd8;   // wraps modulo 2^32
         default:   o_data = 32'd0;          // memory data not here yet / none
      endcase
   end

   assign o_valid = (i_addr != 5'd0) && (i_tnew == 2'd0) &&
                    (i_op != FW_OP_MEM) && (i_op != FW_OP_NONE);

endmodule

// File: rtl/em_stage_reg.sv
// em_stage_reg: E->M pipeline register with forwarding tags.
//   clk, reset       clock; asynchronous active-high reset
//   en, flush        capture enable (0 = stall); flush loads a bubble
//   E_*              values of the instruction currently in E
//   M_*              registered copies for the M stage
//   M_fw_data        forward value sourced from M (combinational)
//   M_fw_valid       1 = M_fw_data usable by D/E forwarding this cycle
module em_stage_reg
   import em_stage_reg_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        flush,
   input  logic [31:0] E_pc,
   input  logic [31:0] E_instr,
   input  logic [31:0] E_alu_out,
   input  logic [31:0] E_rt_data,
   input  logic [4:0]  E_fw_addr,
   input  logic [1:0]  E_fw_data_op,
   input  logic [1:0]  E_tnew,
   output logic [31:0] M_pc,
   output logic [31:0] M_instr,
   output logic [31:0] M_alu_out,
   output logic [31:0] M_rt_data,
   output logic [4:0]  M_fw_addr,
   output logic [1:0]  M_fw_data_op,
   output logic [1:0]  M_tnew,
   output logic [31:0] M_fw_data,
   output logic        M_fw_valid
);

   // An instruction with no result (either tag says so) is normalised to
   // the bubble tags so downstream stages see one canonical "no forward".
   logic w_no_result;
   assign w_no_result = (E_tnew == TNEW_NONE) || (E_fw_data_op == FW_OP_NONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         M_pc         <= RESET_PC;
         M_instr      <= 32'd0;
         M_alu_out    <= 32'd0;
         M_rt_data    <= 32'd0;
         M_fw_addr    <= 5'd0;
         M_fw_data_op <= FW_OP_NONE;
         M_tnew       <= 2'd0;
      end else if (flush) begin
         M_pc         <= RESET_PC;
         M_instr      <= 32'd0;
         M_alu_out    <= 32'd0;
         M_rt_data    <= 32'd0;
         M_fw_addr    <= 5'd0;
         M_fw_data_op <= FW_OP_NONE;
         M_tnew       <= 2'd0;
      end else if (en) begin
         M_pc         <= E_pc;
         M_instr      <= E_instr;
         M_alu_out    <= E_alu_out;
         M_rt_data    <= E_rt_data;
         // E_fw_addr==0 already yields 0, so only the no-result case needs care
         M_fw_addr    <= w_no_result ? 5'd0       : E_fw_addr;
         M_fw_data_op <= w_no_result ? FW_OP_NONE : E_fw_data_op;
         M_tnew       <= w_no_result ? 2'd0       : tnew_next(E_tnew);
      end
      // en=0: hold everything, Tnew does not count down during a stall
   end

   fw_data_sel u_fw_sel (
      .i_op    (M_fw_data_op),
      .i_addr  (M_fw_addr),
      .i_tnew  (M_tnew),
      .i_alu   (M_alu_out),
      .i_pc    (M_pc),
      .o_data  (M_fw_data),
      .o_valid (M_fw_valid)
   );

endmodule

// File: tb/tb_em_stage_reg.sv
module tb_em_stage_reg;

   logic        clk = 1'b0;
   logic        reset, en, flush;
   logic [31:0] E_pc, E_instr, E_alu_out, E_rt_data;
   logic [4:0]  E_fw_addr;
   logic [1:0]  E_fw_data_op, E_tnew;
   logic [31:0] M_pc, M_instr, M_alu_out, M_rt_data, M_fw_data;
   logic [4:0]  M_fw_addr;
   logic [1:0]  M_fw_data_op, M_tnew;
   logic        M_fw_valid;

   int checks = 0;
   int errors = 0;

   // reference state of the M stage
   logic [31:0] x_pc, x_instr, x_alu, x_rt;
   logic [4:0]  x_addr;
   logic [1:0]  x_op, x_tnew;

   em_stage_reg dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .E_pc(E_pc), .E_instr(E_instr), .E_alu_out(E_alu_out), .E_rt_data(E_rt_data),
      .E_fw_addr(E_fw_addr), .E_fw_data_op(E_fw_data_op), .E_tnew(E_tnew),
      .M_pc(M_pc), .M_instr(M_instr), .M_alu_out(M_alu_out), .M_rt_data(M_rt_data),
      .M_fw_addr(M_fw_addr), .M_fw_data_op(M_fw_data_op), .M_tnew(M_tnew),
      .M_fw_data(M_fw_data), .M_fw_valid(M_fw_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_bubble();
      x_pc = 32'h0000_3000; x_instr = 0; x_alu = 0; x_rt = 0;
      x_addr = 0; x_op = 2'b11; x_tnew = 0;
   endtask

   // what one clock edge does to the M stage, from the rules as written
   task automatic model_edge();
      if (reset || flush) model_bubble();
      else if (en) begin
         x_pc = E_pc; x_instr = E_instr; x_alu = E_alu_out; x_rt = E_rt_data;
         if (E_tnew == 3 || E_fw_data_op == 3) begin
            x_addr = 0; x_op = 3; x_tnew = 0;
         end else begin
            x_addr = E_fw_addr; x_op = E_fw_data_op;
            x_tnew = (E_tnew == 0) ? 2'd0 : 2'(E_tnew - 1);
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] fd;
      logic        fv;
      case (x_op)
         2'd0:    fd = x_alu;
         2'd2:    fd = 32'(x_pc + 32'd8);
         default: fd = 0;
      endcase
      fv = (x_addr != 0) && (x_tnew == 0) && (x_op == 0 || x_op == 2);
      chk({tag, ".pc"},    M_pc,         x_pc);
      chk({tag, ".instr"}, M_instr,      x_instr);
      chk({tag, ".alu"},   M_alu_out,    x_alu);
      chk({tag, ".rt"},    M_rt_data,    x_rt);
      chk({tag, ".addr"},  32'(M_fw_addr),    32'(x_addr));
      chk({tag, ".op"},    32'(M_fw_data_op), 32'(x_op));
      chk({tag, ".tnew"},  32'(M_tnew),       32'(x_tnew));
      chk({tag, ".fwd"},   M_fw_data,    fd);
      chk({tag, ".fwv"},   32'(M_fw_valid),   32'(fv));
   endtask

   task automatic set_e(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] rt, input logic [4:0] a, input logic [1:0] op,
                        input logic [1:0] t);
      E_pc = pc; E_instr = ins; E_alu_out = alu; E_rt_data = rt;
      E_fw_addr = a; E_fw_data_op = op; E_tnew = t;
   endtask

   // called at a negedge; returns at the next negedge
   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1 check_all(tag);
      @(negedge clk);
   endtask

   initial begin
      reset = 1; en = 0; flush = 0;
      set_e(0, 0, 0, 0, 0, 0, 0);
      model_bubble();
      @(negedge clk); @(negedge clk);
      check_all("rst");
      reset = 0;

      // add $3: alu=5, tnew 1
      en = 1;
      set_e(32'h3000, 32'h0043_1820, 5, 7, 3, 2'b00, 2'd1);
      step("add");
      chk("add.tnew0", 32'(M_tnew), 0);
      chk("add.fwd5", M_fw_data, 5);
      chk("add.valid", 32'(M_fw_valid), 1);

      // lw $4: op 01, tnew 2
      set_e(32'h3004, 32'h8c04_0000, 32'h100, 9, 4, 2'b01, 2'd2);
      step("lw");
      chk("lw.tnew1", 32'(M_tnew), 1);
      chk("lw.valid", 32'(M_fw_valid), 0);

      // jal link value and wrap
      set_e(32'h0000_3004, 32'h0c00_0000, 0, 0, 31, 2'b10, 2'd0);
      step("jal");
      chk("jal.fwd", M_fw_data, 32'h0000_300C);
      set_e(32'hFFFF_FFFC, 32'h0c00_0000, 0, 0, 31, 2'b10, 2'd0);
      step("jalw");
      chk("jalw.fwd", M_fw_data, 32'h0000_0004);

      // capture add, then stall 3 cycles with E changing
      set_e(32'h3010, 32'h0043_1820, 11, 2, 3, 2'b00, 2'd1);
      step("cap");
      en = 0;
      for (int i = 0; i < 3; i++) begin
         set_e($urandom, $urandom, $urandom, $urandom, 5'($urandom), 2'($urandom), 2'($urandom));
         step("hold");
         chk("hold.tnew", 32'(M_tnew), 0);
         chk("hold.pc", M_pc, 32'h3010);
      end

      // flush wins over en
      en = 1; flush = 1;
      set_e(32'h3020, 32'h0043_1820, 5, 0, 3, 2'b00, 2'd1);
      step("flush");
      chk("flush.pc", M_pc, 32'h3000);
      chk("flush.valid", 32'(M_fw_valid), 0);
      flush = 0;

      // async reset mid-cycle after a captured add
      step("pre");
      reset = 1;
      #1 model_bubble();
      check_all("arst");
      @(negedge clk);
      reset = 0;

      // add targeting $0, and tnew=11 with a nonzero addr
      set_e(32'h3030, 32'h0040_0020, 8, 0, 0, 2'b00, 2'd1);
      step("zero");
      chk("zero.addr", 32'(M_fw_addr), 0);
      set_e(32'h3034, 32'hac00_0000, 8, 6, 9, 2'b00, 2'd3);
      step("none");

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         en    = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 7) == 0);
         set_e($urandom, $urandom, $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               2'($urandom), 2'($urandom));
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
